// File: rtl/shift_reg_pkg.sv
// Shared constants for the shift-register chain (PISO / SISO / SIPO stages).
package shift_reg_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Level driven on the serial line when no word is in flight.
    localparam logic SER_IDLE = 1'b0;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side outputs of the PISO serializer.
interface piso_serializer_if
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] Din_par;
    logic             Dout;
    logic             busy;
    logic             frame_start;
    logic             last_bit;

    modport master (
        output load_valid,
        output Din_par,
        input  load_ready,
        input  Dout,
        input  busy,
        input  frame_start,
        input  last_bit
    );

    modport slave (
        input  load_valid,
        input  Din_par,
        output load_ready,
        output Dout,
        output busy,
        output frame_start,
        output last_bit
    );

endinterface

// File: rtl/bit_counter.sv
// Bit position counter shared by the serializer and deserializer stages.
module bit_counter
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    localparam int unsigned CW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          terminal
);

    // Clear wins over increment; the owner never enables past WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage: takes a word on a valid/ready handshake and
// shifts it out one bit per clock, gap-free when words arrive back-to-back.
module piso_serializer
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);

    localparam int unsigned SW = WIDTH - 1;
    localparam int unsigned CW = $clog2(WIDTH);

    state_e          state_q, state_n;
    logic            dout_q, dout_n;
    logic            fs_q, fs_n;
    logic [SW-1:0]   shreg_q, shreg_n;

    logic [CW-1:0]   bit_cnt;
    logic            cnt_term;
    logic            cnt_clr;
    logic            cnt_en;

    logic            busy;
    logic            last_bit;
    logic            load_ready;
    logic            accept;

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (bit_cnt),
        .terminal (cnt_term)
    );

    // Handshake terms derive from registers only, never from load_valid.
    assign busy       = (state_q == S_SHIFT);
    assign last_bit   = busy & cnt_term;
    assign load_ready = ~busy | cnt_term;
    assign accept     = bus.load_valid & load_ready;

    // Next-state, shift datapath and counter control.
    always_comb begin
        state_n = state_q;
        dout_n  = dout_q;
        shreg_n = shreg_q;
        fs_n    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (accept) begin
            // Same load path from IDLE and from the last bit of a word.
            state_n = S_SHIFT;
            fs_n    = 1'b1;
            cnt_clr = 1'b1;
            if (LSB_FIRST) begin
                dout_n  = bus.Din_par[0];
                shreg_n = bus.Din_par[WIDTH-1:1];
            end else begin
                dout_n  = bus.Din_par[WIDTH-1];
                shreg_n = bus.Din_par[SW-1:0];
            end
        end else if (busy) begin
            if (cnt_term) begin
                state_n = S_IDLE;
                dout_n  = SER_IDLE;
                cnt_clr = 1'b1;
            end else begin
                cnt_en = 1'b1;
                if (LSB_FIRST) begin
                    dout_n  = shreg_q[0];
                    shreg_n = shreg_q >> 1;
                end else begin
                    dout_n  = shreg_q[SW-1];
                    shreg_n = shreg_q << 1;
                end
            end
        end
    end

    // State, serial output and shift register; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dout_q  <= SER_IDLE;
            fs_q    <= 1'b0;
            shreg_q <= '0;
        end else begin
            state_q <= state_n;
            dout_q  <= dout_n;
            fs_q    <= fs_n;
            shreg_q <= shreg_n;
        end
    end

    assign bus.Dout        = dout_q;
    assign bus.busy        = busy;
    assign bus.frame_start = fs_q;
    assign bus.last_bit    = last_bit;
    assign bus.load_ready  = load_ready;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one LSB-first and one MSB-first instance.
module tb_piso_serializer;

    logic clk;
    logic rst_n;

    int tests;
    int fails;

    piso_serializer_if #(.WIDTH(4)) ifa ();
    piso_serializer_if #(.WIDTH(4)) ifb ();

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next falling edge and check every output of the LSB-first instance.
    task automatic cyc_a(input string tag, input logic d, input logic b,
                         input logic fs, input logic lb, input logic lr);
        @(negedge clk);
        chk({tag, ".dout"},  32'(ifa.Dout),        32'(d));
        chk({tag, ".busy"},  32'(ifa.busy),        32'(b));
        chk({tag, ".fs"},    32'(ifa.frame_start), 32'(fs));
        chk({tag, ".last"},  32'(ifa.last_bit),    32'(lb));
        chk({tag, ".ready"}, 32'(ifa.load_ready),  32'(lr));
    endtask

    task automatic cyc_b(input string tag, input logic d, input logic b,
                         input logic fs, input logic lb, input logic lr);
        @(negedge clk);
        chk({tag, ".dout"},  32'(ifb.Dout),        32'(d));
        chk({tag, ".busy"},  32'(ifb.busy),        32'(b));
        chk({tag, ".fs"},    32'(ifb.frame_start), 32'(fs));
        chk({tag, ".last"},  32'(ifb.last_bit),    32'(lb));
        chk({tag, ".ready"}, 32'(ifb.load_ready),  32'(lr));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset held 3 clocks with valid asserted: nothing may be accepted.
        rst_n          = 1'b0;
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'd14;
        ifb.load_valid = 1'b1;
        ifb.Din_par    = 4'd14;
        cyc_a("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_a("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_b("rst3b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n          = 1'b1;
        ifa.load_valid = 1'b0;
        ifb.load_valid = 1'b0;
        cyc_a("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_b("post_rst_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Single word 14 = 4'b1110, LSB first -> 0,1,1,1.
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'd14;
        cyc_a("single.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.load_valid = 1'b0;
        ifa.Din_par    = 4'bxxxx;
        cyc_a("single.b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("single.b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("single.b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_a("single.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // MSB first: 4'b1000 -> 1,0,0,0.
        ifb.load_valid = 1'b1;
        ifb.Din_par    = 4'b1000;
        cyc_b("msb.b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ifb.load_valid = 1'b0;
        cyc_b("msb.b2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b("msb.b3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b("msb.b4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_b("msb.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back 4'hA then 4'h5 -> 0,1,0,1,1,0,1,0 with no gap.
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'hA;
        cyc_a("b2b.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.Din_par    = 4'h5;
        cyc_a("b2b.b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("b2b.b3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("b2b.b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_a("b2b.b5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.load_valid = 1'b0;
        cyc_a("b2b.b6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("b2b.b7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("b2b.b8", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_a("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: 4'hF offered during bit 2 is held until last_bit.
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'd14;
        cyc_a("bp.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.load_valid = 1'b0;
        cyc_a("bp.b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'hF;
        cyc_a("bp.b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("bp.b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_a("bp.n1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.load_valid = 1'b0;
        cyc_a("bp.n2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("bp.n3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("bp.n4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_a("bp.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Async reset during bit 2 drops the word before the next clock edge.
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'd14;
        cyc_a("ar.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.load_valid = 1'b0;
        cyc_a("ar.b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.async.dout",  32'(ifa.Dout),        32'(1'b0));
        chk("ar.async.busy",  32'(ifa.busy),        32'(1'b0));
        chk("ar.async.fs",    32'(ifa.frame_start), 32'(1'b0));
        chk("ar.async.last",  32'(ifa.last_bit),    32'(1'b0));
        chk("ar.async.ready", 32'(ifa.load_ready),  32'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a("ar.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ifa.load_valid = 1'b1;
        ifa.Din_par    = 4'd14;
        cyc_a("ar.n1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ifa.load_valid = 1'b0;
        cyc_a("ar.n2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("ar.n3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_a("ar.n4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_a("ar.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
